// File: rtl/quic_enc_golomb.sv
// Golomb-limited codeword generator and MSB-first 32-bit bit packer for the QUIC encoder path.
// Defining QUIC_ENC_STATS_EN adds the total_bits port counting appended codeword bits.
module quic_enc_golomb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [7:0]  sym,
    input  logic [2:0]  bestcode,
    input  logic        flush,
    output logic        flush_done,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [31:0] word
`ifdef QUIC_ENC_STATS_EN
    ,
    output logic [31:0] total_bits
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        PAD   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [7:0] nGrCodewords(input logic [2:0] l);
        logic [7:0] v;
        case (l)
            3'd0:    v = 8'h12;
            3'd1:    v = 8'h24;
            3'd2:    v = 8'h48;
            3'd3:    v = 8'h90;
            3'd4:    v = 8'hf0;
            3'd5:    v = 8'he0;
            3'd6:    v = 8'hc0;
            default: v = 8'h80;
        endcase
        return v;
    endfunction

    function automatic logic [4:0] notGrCwLen(input logic [2:0] l);
        logic [4:0] v;
        case (l)
            3'd0:    v = 5'h1a;
            3'd1:    v = 5'h1a;
            3'd2:    v = 5'h1a;
            3'd3:    v = 5'h19;
            3'd4:    v = 5'h13;
            3'd5:    v = 5'h0c;
            3'd6:    v = 5'h09;
            default: v = 5'h08;
        endcase
        return v;
    endfunction

    state_t       state_r;
    state_t       stateNext_s;
    logic [63:0]  acc_r;
    logic [6:0]   fill_r;
    logic         symReady_r;
    logic         wordValid_r;
    logic         flushDone_r;

    logic [7:0]   nGr_s;
    logic [7:0]   lowMask_s;
    logic [25:0]  cw_s;
    logic [4:0]   len_s;
    logic         symFire_s;
    logic         pop_s;
    logic [63:0]  accShift_s;
    logic [6:0]   fillBase_s;
    logic [6:0]   shiftAmt_s;
    logic [63:0]  placed_s;
    logic [63:0]  accNext_s;
    logic [6:0]   fillNext_s;

    assign sym_ready  = symReady_r;
    assign word_valid = wordValid_r;
    assign flush_done = flushDone_r;
    assign word       = acc_r[63:32];

    // Codeword formation: Golomb-Rice below the table limit, fixed-length escape otherwise.
    always_comb begin
        nGr_s     = nGrCodewords(bestcode);
        lowMask_s = (8'd1 << bestcode) - 8'd1;
        if (sym < nGr_s) begin
            cw_s  = {18'd0, (8'd1 << bestcode) | (sym & lowMask_s)};
            len_s = 5'({5'd0, bestcode} + (sym >> bestcode) + 8'd1);
        end else begin
            cw_s  = {18'd0, sym - nGr_s};
            len_s = notGrCwLen(bestcode);
        end
    end

    // Pop-then-append datapath and flush sequencing.
    always_comb begin
        symFire_s   = sym_valid && symReady_r;
        pop_s       = wordValid_r && word_ready;
        accShift_s  = pop_s ? {acc_r[31:0], 32'd0} : acc_r;
        fillBase_s  = pop_s ? (fill_r - 7'd32) : fill_r;
        // fillBase + len never exceeds 57, so the shift stays at 7 or more.
        shiftAmt_s  = 7'd64 - fillBase_s - {2'd0, len_s};
        placed_s    = {38'd0, cw_s} << shiftAmt_s;
        accNext_s   = accShift_s;
        fillNext_s  = fillBase_s;
        stateNext_s = state_r;
        if (symFire_s) begin
            accNext_s  = accShift_s | placed_s;
            fillNext_s = fillBase_s + {2'd0, len_s};
        end else begin
            accNext_s  = accShift_s;
        end
        case (state_r)
            RUN: begin
                if (flush) begin
                    stateNext_s = FLUSH;
                end else begin
                    stateNext_s = RUN;
                end
            end
            FLUSH: begin
                if (fill_r == 7'd0) begin
                    stateNext_s = DONE;
                end else if (fill_r < 7'd32) begin
                    // Bits below the fill point are always zero, so this is the pad.
                    fillNext_s  = 7'd32;
                    stateNext_s = PAD;
                end else begin
                    stateNext_s = FLUSH;
                end
            end
            PAD: begin
                if (pop_s) begin
                    stateNext_s = DONE;
                end else begin
                    stateNext_s = PAD;
                end
            end
            DONE:    stateNext_s = RUN;
            default: stateNext_s = RUN;
        endcase
    end

    // State, accumulator and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= RUN;
            acc_r       <= 64'd0;
            fill_r      <= 7'd0;
            symReady_r  <= 1'b0;
            wordValid_r <= 1'b0;
            flushDone_r <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            acc_r       <= accNext_s;
            fill_r      <= fillNext_s;
            symReady_r  <= (stateNext_s == RUN) && (fillNext_s < 7'd32);
            wordValid_r <= (fillNext_s >= 7'd32);
            flushDone_r <= (stateNext_s == DONE);
        end
    end

`ifdef QUIC_ENC_STATS_EN
    logic [31:0] totalBits_r;

    assign total_bits = totalBits_r;

    // Running count of codeword bits, excluding flush padding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            totalBits_r <= 32'd0;
        end else if (symFire_s) begin
            totalBits_r <= totalBits_r + {27'd0, len_s};
        end else begin
            totalBits_r <= totalBits_r;
        end
    end
`endif

endmodule
